// File: rtl/button_irq_servicer.sv
// Services a button PIO's edge-capture interrupt: reads the capture register, clears it,
// and queues non-zero captures into a 4-deep event FIFO. Optional mask write at start-up
// is enabled by defining BUTTON_IRQ_MASK_INIT_EN.
module button_irq_servicer #(
  parameter logic [3:0] MASK_INIT = 4'hF
) (
  input  logic        clk,
  input  logic        reset,
  output logic [1:0]  avm_address,
  output logic        avm_chipselect,
  output logic        avm_write_n,
  output logic [31:0] avm_writedata,
  input  logic [31:0] avm_readdata,
  input  logic        btn_irq,
  output logic [3:0]  event_data,
  output logic        event_valid,
  input  logic        event_ready,
  input  logic        ovf_clr,
  output logic        overflow,
  output logic [2:0]  fsm_state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    CLR     = 3'd3,
    SETTLE  = 3'd4
`ifdef BUTTON_IRQ_MASK_INIT_EN
    , INIT  = 3'd5
`endif
  } state_t;

  state_t state, state_next;
  logic [3:0] cap;

  logic [3:0] mem [4];
  logic [1:0] wr_ptr, rd_ptr;
  logic [2:0] count;
  logic       push_req, pop, full, push_ok, drop;

  logic unused_bits;
`ifdef BUTTON_IRQ_MASK_INIT_EN
  assign unused_bits = ^avm_readdata[31:4];
`else
  assign unused_bits = ^{avm_readdata[31:4], MASK_INIT};
`endif

  assign fsm_state = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
`ifdef BUTTON_IRQ_MASK_INIT_EN
      state <= INIT;
`else
      state <= IDLE;
`endif
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
`ifdef BUTTON_IRQ_MASK_INIT_EN
      INIT:    state_next = IDLE;
`endif
      IDLE:    state_next = btn_irq ? RD_REQ : IDLE;
      RD_REQ:  state_next = RD_WAIT;
      RD_WAIT: state_next = CLR;
      CLR:     state_next = SETTLE;
      SETTLE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Readdata is registered by the port, so address 3 stays up through RD_WAIT.
  always_comb begin
    avm_address    = 2'd0;
    avm_chipselect = 1'b0;
    avm_write_n    = 1'b1;
    avm_writedata  = 32'h0;
    unique case (state)
`ifdef BUTTON_IRQ_MASK_INIT_EN
      INIT: begin
        if (!reset) begin
          avm_address    = 2'd2;
          avm_chipselect = 1'b1;
          avm_write_n    = 1'b0;
          avm_writedata  = {28'h0, MASK_INIT};
        end
      end
`endif
      RD_REQ: begin
        avm_address    = 2'd3;
        avm_chipselect = 1'b1;
      end
      RD_WAIT: avm_address = 2'd3;
      CLR: begin
        avm_address    = 2'd3;
        avm_chipselect = 1'b1;
        avm_write_n    = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cap <= 4'h0;
    end else if (state == RD_WAIT) begin
      cap <= avm_readdata[3:0];
    end
  end

  // Event stream: a beat transfers on a cycle where event_valid && event_ready; while
  // valid is high and ready is low the head entry (event_data) holds unchanged.
  assign event_valid = (count != 3'd0);
  assign event_data  = event_valid ? mem[rd_ptr] : 4'h0;
  assign pop         = event_valid && event_ready;
  assign full        = (count == 3'd4);
  assign push_req    = (state == CLR) && (cap != 4'h0);
  assign push_ok     = push_req && (!full || pop);
  assign drop        = push_req && full && !pop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) mem[i] <= 4'h0;
      wr_ptr   <= 2'd0;
      rd_ptr   <= 2'd0;
      count    <= 3'd0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= cap;
        wr_ptr      <= wr_ptr + 2'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      unique case ({push_ok, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: ;
      endcase
      // A drop in the same cycle as a clear request wins.
      if (drop) overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

endmodule
